// File: rtl/bit_stream_deser_pkg.sv
// Shared types and constants for the bit stream deserializer.
// FSM encoding, gap counter width, constant clog2 helper.
package bit_stream_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam int GAP_W = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_stream_gap_timer.sv
// Saturating inter-bit gap counter; flags the TIMEOUT-th idle cycle.
// TIMEOUT of 0 keeps expire low permanently.
module bit_stream_gap_timer
    import bit_stream_deser_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam bit TMO_ON = (TIMEOUT > 0);
    localparam logic [GAP_W-1:0] LIMIT =
        TMO_ON ? GAP_W'(TIMEOUT - 1) : '0;

    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gap_cnt <= '0;
        end else if (clear || !enable) begin
            gap_cnt <= '0;
        end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // gap_cnt idle cycles already elapsed; this cycle would be the TIMEOUT-th
    assign expire = TMO_ON && enable && (gap_cnt == LIMIT);

endmodule

// File: rtl/bit_stream_deser.sv
// Collects valid-strobed serial bits into WIDTH-bit words on a valid/ready port.
// Optional even parity bit per word: define BIT_STREAM_DESER_PARITY_EN.
module bit_stream_deser
    import bit_stream_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int TIMEOUT   = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             DIN,
    input  logic             DIN_DV,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_DV,
    input  logic             DOUT_RDY,
    output logic             OVF,
    output logic             ABORT,
    output logic             PAR_ERR
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] word;
    logic             expire;
    logic             last_bit;
    logic             shift_en;
    logic             done;
    logic             word_ok;
    logic             abort_now;
    logic             accept;
    logic             load;
    logic             drop;

    bit_stream_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clear  (DIN_DV),
        .enable (state_q != ST_IDLE),
        .expire (expire)
    );

    assign last_bit = (bit_cnt == LAST);

    always_comb begin
        if (MSB_FIRST != 0) begin
            sh_d = {sh_q[WIDTH-2:0], DIN};
        end else begin
            sh_d = {DIN, sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (DIN_DV) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (DIN_DV && last_bit) begin
`ifdef BIT_STREAM_DESER_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = ST_IDLE;
`endif
                end else if (expire && !DIN_DV) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAR: begin
                if (DIN_DV || expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        done      = 1'b0;
        word_ok   = 1'b1;
        abort_now = 1'b0;
        word      = sh_d;
        unique case (state_q)
            ST_IDLE: begin
                shift_en = DIN_DV;
            end
            ST_DATA: begin
                shift_en  = DIN_DV;
                abort_now = expire && !DIN_DV;
`ifndef BIT_STREAM_DESER_PARITY_EN
                done      = DIN_DV && last_bit;
`endif
            end
            ST_PAR: begin
                abort_now = expire && !DIN_DV;
`ifdef BIT_STREAM_DESER_PARITY_EN
                done      = DIN_DV;
                word_ok   = ~((^sh_q) ^ DIN);
                word      = sh_q;
`endif
            end
            default: ;
        endcase
    end

    assign accept = DOUT_DV && DOUT_RDY;
    assign load   = done && word_ok && (!DOUT_DV || DOUT_RDY);
    assign drop   = done && word_ok && DOUT_DV && !DOUT_RDY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_q    <= '0;
            bit_cnt <= '0;
            DOUT    <= '0;
            DOUT_DV <= 1'b0;
            OVF     <= 1'b0;
            ABORT   <= 1'b0;
        end else begin
            if (shift_en) begin
                sh_q <= sh_d;
            end
            if (abort_now || (shift_en && last_bit)) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (load) begin
                DOUT <= word;
            end
            if (load) begin
                DOUT_DV <= 1'b1;
            end else if (accept) begin
                DOUT_DV <= 1'b0;
            end
            OVF   <= drop;
            ABORT <= abort_now;
        end
    end

`ifdef BIT_STREAM_DESER_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PAR_ERR <= 1'b0;
        end else begin
            PAR_ERR <= done && !word_ok;
        end
    end
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bit_stream_deser.sv
// Bench for bit_stream_deser: two instances (LSB-first with timeout, MSB-first
// without) driven by shared stimulus and checked against a bit-list model.
module tb_bit_stream_deser;

`ifdef BIT_STREAM_DESER_PARITY_EN
    localparam int NB = 9;
    localparam bit PEN = 1'b1;
`else
    localparam int NB = 8;
    localparam bit PEN = 1'b0;
`endif

    logic       CLK;
    logic       RST_N;
    logic       DIN;
    logic       DIN_DV;
    logic       DOUT_RDY;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, ovf0, ovf1, ab0, ab1, pe0, pe1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_dout [2];
    logic       m_dv   [2];
    logic       m_ovf  [2];
    logic       m_ab   [2];
    logic       m_pe   [2];
    logic [8:0] m_bits [2];
    int         m_nb   [2];
    int         m_gap  [2];

    bit_stream_deser #(.WIDTH(8), .MSB_FIRST(0), .TIMEOUT(10)) u0 (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_DV(DIN_DV),
        .DOUT(dout0), .DOUT_DV(dv0), .DOUT_RDY(DOUT_RDY),
        .OVF(ovf0), .ABORT(ab0), .PAR_ERR(pe0)
    );

    bit_stream_deser #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(0)) u1 (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_DV(DIN_DV),
        .DOUT(dout1), .DOUT_DV(dv1), .DOUT_RDY(DOUT_RDY),
        .OVF(ovf1), .ABORT(ab1), .PAR_ERR(pe1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dout[i] = '0; m_dv[i] = 0; m_ovf[i] = 0;
            m_ab[i] = 0; m_pe[i] = 0; m_bits[i] = '0;
            m_nb[i] = 0; m_gap[i] = 0;
        end
    endtask

    // One clock of the reference: bits collected into a list, word formed
    // when the list holds a full frame, idle cycles counted inside a frame.
    task automatic model_step(input int i, input logic d, input logic v,
                              input logic r);
        logic [7:0] w;
        bit full;
        int tmo;
        tmo = (i == 0) ? 10 : 0;
        full = m_dv[i] && !r;
        m_ovf[i] = 0; m_ab[i] = 0; m_pe[i] = 0;
        if (m_dv[i] && r) m_dv[i] = 0;
        if (v) begin
            m_bits[i][m_nb[i]] = d;
            m_nb[i]++;
            m_gap[i] = 0;
            if (m_nb[i] == NB) begin
                for (int k = 0; k < 8; k++)
                    w[(i == 1) ? 7 - k : k] = m_bits[i][k];
                m_nb[i] = 0;
                if (PEN && (^m_bits[i][NB-1:0])) m_pe[i] = 1;
                else if (full) m_ovf[i] = 1;
                else begin
                    m_dout[i] = w;
                    m_dv[i] = 1;
                end
            end
        end else if (m_nb[i] > 0) begin
            m_gap[i]++;
            if (tmo > 0 && m_gap[i] == tmo) begin
                m_ab[i] = 1;
                m_nb[i] = 0;
                m_gap[i] = 0;
            end
        end
    endtask

    task automatic cmp_all();
        check("dout0", dout0, m_dout[0]);
        check("dv0", dv0, m_dv[0]);
        check("ovf0", ovf0, m_ovf[0]);
        check("abort0", ab0, m_ab[0]);
        check("parerr0", pe0, m_pe[0]);
        check("dout1", dout1, m_dout[1]);
        check("dv1", dv1, m_dv[1]);
        check("ovf1", ovf1, m_ovf[1]);
        check("abort1", ab1, m_ab[1]);
        check("parerr1", pe1, m_pe[1]);
    endtask

    task automatic cyc(input logic d, input logic v, input logic r);
        DIN = d; DIN_DV = v; DOUT_RDY = r;
        model_step(0, d, v, r);
        model_step(1, d, v, r);
        @(posedge CLK);
        #1;
        cmp_all();
    endtask

    task automatic send_word(input logic [7:0] d, input int gap,
                             input logic r, input logic r_last,
                             input bit bad);
        logic [8:0] b;
        b = {(^d) ^ bad, d};
        for (int k = 0; k < NB; k++) begin
            cyc(b[k], 1'b1, (k == NB - 1) ? r_last : r);
            if (k != NB - 1) repeat (gap - 1) cyc(1'b0, 1'b0, r);
        end
    endtask

    task automatic zero_outs(input string tag);
        check({tag, "_dout0"}, dout0, 8'h00);
        check({tag, "_dv0"}, dv0, 1'b0);
        check({tag, "_ovf0"}, ovf0, 1'b0);
        check({tag, "_ab0"}, ab0, 1'b0);
        check({tag, "_pe0"}, pe0, 1'b0);
        check({tag, "_dout1"}, dout1, 8'h00);
        check({tag, "_dv1"}, dv1, 1'b0);
    endtask

    initial begin
        logic [8:0] b;
        DIN = 0; DIN_DV = 0; DOUT_RDY = 0; RST_N = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        zero_outs("reset");
        RST_N = 1;

        send_word(8'h4D, 2, 1'b1, 1'b1, 0);
        check("t1_dout0", dout0, 8'h4D);
        check("t1_dv0", dv0, 1'b1);
        check("t2_dout1", dout1, 8'hB2);
        cyc(1'b0, 1'b0, 1'b1);
        check("t1_dv0_drop", dv0, 1'b0);
        check("t1_dout0_keep", dout0, 8'h4D);

        send_word(8'h55, 1, 1'b1, 1'b1, 0);
        check("t2_w1_dout0", dout0, 8'h55);
        check("t2_w1_dout1", dout1, 8'hAA);
        send_word(8'h55, 1, 1'b1, 1'b1, 0);
        check("t2_w2_dout0", dout0, 8'h55);
        cyc(1'b0, 1'b0, 1'b1);

        send_word(8'h01, 2, 1'b0, 1'b0, 0);
        check("t3_w1_dout0", dout0, 8'h01);
        send_word(8'h02, 2, 1'b0, 1'b0, 0);
        check("t3_w2_ovf0", ovf0, 1'b1);
        send_word(8'h03, 2, 1'b0, 1'b0, 0);
        check("t3_w3_ovf0", ovf0, 1'b1);
        check("t3_hold_dout0", dout0, 8'h01);
        cyc(1'b0, 1'b0, 1'b0);
        check("t3_ovf_pulse", ovf0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("t3_accept_dv0", dv0, 1'b0);

        send_word(8'h11, 2, 1'b0, 1'b0, 0);
        send_word(8'h22, 2, 1'b0, 1'b1, 0);
        check("t4_dout0", dout0, 8'h22);
        check("t4_dv0", dv0, 1'b1);
        check("t4_ovf0", ovf0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);

        repeat (5) cyc(1'b1, 1'b1, 1'b1);
        repeat (9) cyc(1'b0, 1'b0, 1'b1);
        check("t5_no_early_abort", ab0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("t5_abort", ab0, 1'b1);
        check("t5_abort_dv0", dv0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("t5_abort_pulse", ab0, 1'b0);
        send_word(8'h3C, 2, 1'b1, 1'b1, 0);
        check("t5_clean_dout0", dout0, 8'h3C);
        b = {^8'h96, 8'h96};
        for (int k = 0; k < NB; k++) begin
            cyc(b[k], 1'b1, 1'b1);
            if (k == 3) check("t5_dv_wins", ab0, 1'b0);
            if (k == 2) repeat (9) cyc(1'b0, 1'b0, 1'b1);
        end
        check("t5_late_dout0", dout0, 8'h96);
        cyc(1'b0, 1'b0, 1'b1);

`ifdef BIT_STREAM_DESER_PARITY_EN
        send_word(8'h4D, 2, 1'b1, 1'b1, 0);
        check("t6_par_ok", dout0, 8'h4D);
        cyc(1'b0, 1'b0, 1'b1);
        send_word(8'h4D, 2, 1'b1, 1'b1, 1);
        check("t6_par_err", pe0, 1'b1);
        check("t6_par_dv0", dv0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
`endif

        repeat (4) cyc(1'b1, 1'b1, 1'b1);
        RST_N = 0;
        DIN_DV = 0;
        #2;
        model_reset();
        zero_outs("midreset");
        @(posedge CLK);
        #1;
        RST_N = 1;
        send_word(8'hA7, 2, 1'b1, 1'b1, 0);
        check("t6_rst_dout0", dout0, 8'hA7);
        check("t6_rst_dout1", dout1, 8'hE5);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 60) == 0)
                repeat (12) cyc(1'b0, 1'b0, $urandom_range(0, 3) != 0);
            else
                cyc(1'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
